// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Purpose:
//   Takes two 7-bit binary display values (e.g. hours/minutes), converts each
//   one to two BCD digits with an iterative shift-add-3 (double dabble)
//   sequencer, and time-multiplexes four common-anode 7-segment digits.
//   Each digit pair can be blinked independently for set mode. Values above
//   99 are shown as "--" on their pair.
//
// Parameters:
//   SCAN_DIV   clock cycles each digit stays lit
//   BLINK_DIV  clock cycles per blink half-period
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  when defined, a left tens digit of 0 (not
//                          overrange) is blanked (its anode stays dark).
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   left_value   binary value for the left digit pair (0..127)
//   right_value  binary value for the right digit pair (0..127)
//   blink_left   blank the left pair during the blink-off phase
//   blink_right  blank the right pair during the blink-off phase
//   dots         lights the decimal point of digit 2
//   seg          segments g..a, active-low (seg[0] = a)
//   dp           decimal point, active-low
//   an           digit anodes, active-low one-hot
//                (an[3] left tens, an[2] left units, an[1] right tens,
//                 an[0] right units)
//   conv_done    one-cycle pulse when new BCD digits are committed
// ---------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] left_value,
    input  logic [6:0] right_value,
    input  logic       blink_left,
    input  logic       blink_right,
    input  logic       dots,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       conv_done
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  SCAN_ONE  = SCAN_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE = BLINK_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // One double-dabble iteration on {tens, units, binary}: correct each
    // nibble first, then shift the whole register so the shift sees the
    // corrected nibbles.
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = v[14:11];
        u = v[10:7];
        if (t >= 4'd5) begin
            t = t + 4'd3;
        end else begin
            t = t;
        end
        if (u >= 4'd5) begin
            u = u + 4'd3;
        end else begin
            u = u;
        end
        return {t[2:0], u, v[6:0], 1'b0};
    endfunction

    // Active-low segment pattern for a BCD digit; non-decimal codes go dark.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [6:0]         left_cap_r;
    logic [6:0]         right_cap_r;
    logic [14:0]        left_sh_r;
    logic [14:0]        right_sh_r;
    logic [2:0]         iter_r;
    logic [3:0]         left_tens_r;
    logic [3:0]         left_units_r;
    logic [3:0]         right_tens_r;
    logic [3:0]         right_units_r;
    logic               left_over_r;
    logic               right_over_r;
    logic               conv_done_r;
    logic               diff_s;

    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [1:0]         scan_idx_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_off_r;

    logic [3:0]         digit_s;
    logic               over_s;
    logic               side_blink_s;
    logic               lz_dark_s;
    logic               dark_s;
    logic [6:0]         seg_s;
    logic [3:0]         an_s;
    logic               dp_s;
    logic [6:0]         seg_r;
    logic [3:0]         an_r;
    logic               dp_r;

    // Compare live inputs against the captured pair, so a value that changed
    // mid-conversion is picked up as soon as the FSM is idle again.
    assign diff_s = (left_value != left_cap_r) || (right_value != right_cap_r);

    // Conversion FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Conversion FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (diff_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (iter_r == 3'd6) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Conversion datapath: capture, shift registers, committed digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_cap_r    <= 7'd0;
            right_cap_r   <= 7'd0;
            left_sh_r     <= 15'd0;
            right_sh_r    <= 15'd0;
            iter_r        <= 3'd0;
            left_tens_r   <= 4'd0;
            left_units_r  <= 4'd0;
            right_tens_r  <= 4'd0;
            right_units_r <= 4'd0;
            left_over_r   <= 1'b0;
            right_over_r  <= 1'b0;
            conv_done_r   <= 1'b0;
        end else begin
            conv_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (diff_s) begin
                        left_cap_r  <= left_value;
                        right_cap_r <= right_value;
                    end else begin
                        left_cap_r  <= left_cap_r;
                        right_cap_r <= right_cap_r;
                    end
                end
                ST_LOAD: begin
                    left_sh_r  <= {8'd0, left_cap_r};
                    right_sh_r <= {8'd0, right_cap_r};
                    iter_r     <= 3'd0;
                end
                ST_SHIFT: begin
                    left_sh_r  <= dd_step(left_sh_r);
                    right_sh_r <= dd_step(right_sh_r);
                    iter_r     <= iter_r + 3'd1;
                end
                ST_COMMIT: begin
                    left_tens_r   <= left_sh_r[14:11];
                    left_units_r  <= left_sh_r[10:7];
                    right_tens_r  <= right_sh_r[14:11];
                    right_units_r <= right_sh_r[10:7];
                    left_over_r   <= (left_cap_r  > 7'd99);
                    right_over_r  <= (right_cap_r > 7'd99);
                    conv_done_r   <= 1'b1;
                end
                default: begin
                    conv_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Scan divider and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_r <= {SCAN_W{1'b0}};
            scan_idx_r <= 2'd0;
        end else if (scan_cnt_r == SCAN_MAX) begin
            scan_cnt_r <= {SCAN_W{1'b0}};
            scan_idx_r <= scan_idx_r + 2'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_ONE;
            scan_idx_r <= scan_idx_r;
        end
    end

    // Blink divider and phase (phase starts visible).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
            blink_off_r <= 1'b0;
        end else if (blink_cnt_r == BLINK_MAX) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
            blink_off_r <= ~blink_off_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_ONE;
            blink_off_r <= blink_off_r;
        end
    end

    // Select the digit for the current slot and build the next outputs.
    always_comb begin
        digit_s      = 4'd0;
        over_s       = 1'b0;
        side_blink_s = 1'b0;
        case (scan_idx_r)
            2'd0: begin
                digit_s      = right_units_r;
                over_s       = right_over_r;
                side_blink_s = blink_right;
            end
            2'd1: begin
                digit_s      = right_tens_r;
                over_s       = right_over_r;
                side_blink_s = blink_right;
            end
            2'd2: begin
                digit_s      = left_units_r;
                over_s       = left_over_r;
                side_blink_s = blink_left;
            end
            2'd3: begin
                digit_s      = left_tens_r;
                over_s       = left_over_r;
                side_blink_s = blink_left;
            end
            default: begin
                digit_s      = 4'd0;
                over_s       = 1'b0;
                side_blink_s = 1'b0;
            end
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        lz_dark_s = (scan_idx_r == 2'd3) && (left_tens_r == 4'd0) && !left_over_r;
`else
        lz_dark_s = 1'b0;
`endif

        dark_s = (blink_off_r && side_blink_s) || lz_dark_s;

        if (dark_s) begin
            seg_s = 7'h7F;
            an_s  = 4'hF;
        end else if (over_s) begin
            seg_s = 7'h3F;
            an_s  = ~(4'b0001 << scan_idx_r);
        end else begin
            seg_s = seg_of(digit_s);
            an_s  = ~(4'b0001 << scan_idx_r);
        end

        dp_s = ~((scan_idx_r == 2'd2) && dots);
    end

    // Registered display outputs (one clock behind the scan index).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_r <= 7'h7F;
            an_r  <= 4'hF;
            dp_r  <= 1'b1;
        end else begin
            seg_r <= seg_s;
            an_r  <= an_s;
            dp_r  <= dp_s;
        end
    end

    assign seg       = seg_r;
    assign an        = an_r;
    assign dp        = dp_r;
    assign conv_done = conv_done_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//
// Self-checking bench for seven_seg_scan_driver. Expected per-slot segment
// patterns are pushed to a queue when a value is driven and popped when
// conv_done appears, then compared against what the scan shows. Scan,
// blink and decimal-point behaviour are checked per clock against a small
// cycle-count model. Honours LEADING_ZERO_BLANK_EN for the expected values.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    localparam int SD = 2;
    localparam int BD = 8;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB_ON = 1'b1;
`else
    localparam bit LZB_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [6:0] left_value;
    logic [6:0] right_value;
    logic       blink_left;
    logic       blink_right;
    logic       dots;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       conv_done;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int rel0       = 0;
    int done_cnt   = 0;
    int done_cyc   = 0;
    int done_seen  = 0;
    logic [6:0] slot_seg [4];
    int         slot_cyc [4] = '{-1, -1, -1, -1};
    logic [31:0] sb [$];

    seven_seg_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk         (clk),
        .rst         (rst),
        .left_value  (left_value),
        .right_value (right_value),
        .blink_left  (blink_left),
        .blink_right (blink_right),
        .dots        (dots),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .conv_done   (conv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: conv_done pulses and last pattern per slot.
    always @(negedge clk) begin
        if (conv_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        case (an)
            4'b1110: begin slot_seg[0] = seg; slot_cyc[0] = cyc; end
            4'b1101: begin slot_seg[1] = seg; slot_cyc[1] = cyc; end
            4'b1011: begin slot_seg[2] = seg; slot_cyc[2] = cyc; end
            4'b0111: begin slot_seg[3] = seg; slot_cyc[3] = cyc; end
            default: begin end
        endcase
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        if (obs !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Per-slot expectation {dark, seg}; 8'h80 means the slot never lights.
    function automatic logic [31:0] exp_slots(input int l, input int r);
        logic [7:0] s3, s2, s1, s0;
        if (l > 99) begin
            s3 = 8'h3F;
            s2 = 8'h3F;
        end else begin
            s3 = {1'b0, ref_seg(l / 10)};
            s2 = {1'b0, ref_seg(l % 10)};
            if (LZB_ON && l < 10) s3 = 8'h80;
        end
        if (r > 99) begin
            s1 = 8'h3F;
            s0 = 8'h3F;
        end else begin
            s1 = {1'b0, ref_seg(r / 10)};
            s0 = {1'b0, ref_seg(r % 10)};
        end
        return {s3, s2, s1, s0};
    endfunction

    // Expected anodes after the n-th clock edge since reset release.
    function automatic logic [3:0] model_an(input int n, input logic bl, input logic br, input logic lz);
        int idx;
        int ph;
        logic dark;
        logic [3:0] one;
        one  = 4'b0001;
        idx  = ((n - 1) / SD) % 4;
        ph   = ((n - 1) / BD) % 2;
        dark = (ph == 1 && ((idx >= 2) ? bl : br)) || (idx == 3 && lz);
        return dark ? 4'hF : ~(one << idx);
    endfunction

    function automatic logic model_dp(input int n, input logic dt);
        int idx;
        idx = ((n - 1) / SD) % 4;
        return (idx == 2 && dt) ? 1'b0 : 1'b1;
    endfunction

    // Check an/dp (and optionally seg == "0") every clock for a window.
    task automatic scan_check(input int ticks, input logic bl, input logic br,
                              input logic dt, input logic lz, input logic chk_seg);
        int n;
        logic [3:0] ea;
        for (int k = 0; k < ticks; k++) begin
            tick();
            n  = cyc - rel0;
            ea = model_an(n, bl, br, lz);
            check_value("an", {28'd0, an}, {28'd0, ea});
            check_value("dp", {31'd0, dp}, {31'd0, model_dp(n, dt)});
            if (chk_seg && ea != 4'hF) check_value("seg_zero", {25'd0, seg}, 32'h40);
        end
    endtask

    // Wait for the next conv_done, check latency from ref_cyc, then check
    // one full scan round against the popped expectation.
    task automatic check_conv(input int ref_cyc);
        bit got;
        int clr_cyc;
        logic [31:0] e;
        logic [7:0] o;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (done_cnt > done_seen) got = 1'b1;
        end
        check_value("conv_done_seen", {31'd0, got}, 32'd1);
        e = sb.pop_front();
        if (got) begin
            done_seen = done_seen + 1;
            check_value("latency", done_cyc - ref_cyc, 32'd10);
            clr_cyc = cyc;
            repeat (4 * SD) tick();
            for (int i = 0; i < 4; i++) begin
                o = (slot_cyc[i] >= clr_cyc) ? {1'b0, slot_seg[i]} : 8'h80;
                check_value($sformatf("slot%0d", i), {24'd0, o}, {24'd0, e[8*i +: 8]});
            end
        end
    endtask

    int p;
    int first_done;

    initial begin
        rst         = 1'b0;
        left_value  = 7'd0;
        right_value = 7'd0;
        blink_left  = 1'b0;
        blink_right = 1'b0;
        dots        = 1'b0;

        // Reset state
        repeat (3) tick();
        check_value("rst_seg", {25'd0, seg}, 32'h7F);
        check_value("rst_an", {28'd0, an}, 32'hF);
        check_value("rst_dp", {31'd0, dp}, 32'd1);
        check_value("rst_done", {31'd0, conv_done}, 32'd0);

        // Release with inputs 0: plain scan of 00:00, no conversion
        rst  = 1'b1;
        rel0 = cyc;
        scan_check(4 * SD * 2, 1'b0, 1'b0, 1'b0, LZB_ON, 1'b1);
        check_value("no_initial_done", done_cnt, 32'd0);

        // Single value change
        left_value = 7'd23;
        sb.push_back(exp_slots(23, 0));
        check_conv(cyc);

        // Leading zero on the left pair
        left_value = 7'd9;
        sb.push_back(exp_slots(9, 0));
        check_conv(cyc);

        // Overrange on both sides
        left_value  = 7'd127;
        right_value = 7'd100;
        sb.push_back(exp_slots(127, 100));
        check_conv(cyc);

        // Change during conversion is picked up afterwards
        p = cyc;
        left_value  = 7'd99;
        right_value = 7'd45;
        sb.push_back(exp_slots(99, 45));
        sb.push_back(exp_slots(99, 46));
        repeat (4) tick();
        right_value = 7'd46;
        check_conv(p);
        first_done = done_cyc;
        check_conv(first_done);

        // Blink right pair with dots, then blink left pair
        blink_right = 1'b1;
        dots        = 1'b1;
        scan_check(2 * BD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        blink_right = 1'b0;
        dots        = 1'b0;
        blink_left  = 1'b1;
        tick();
        scan_check(2 * BD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        blink_left = 1'b0;

        // Reset in the middle of SHIFT
        left_value = 7'd55;
        repeat (5) tick();
        #2;
        rst         = 1'b0;
        left_value  = 7'd0;
        right_value = 7'd0;
        #1;
        check_value("mid_rst_an", {28'd0, an}, 32'hF);
        check_value("mid_rst_seg", {25'd0, seg}, 32'h7F);
        check_value("mid_rst_done", {31'd0, conv_done}, 32'd0);
        repeat (2) tick();
        rst  = 1'b1;
        rel0 = cyc;
        scan_check(4 * SD * 2, 1'b0, 1'b0, 1'b0, LZB_ON, 1'b1);
        check_value("no_stale_done", done_cnt, done_seen);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
